// File: rtl/rf_pkg.sv
// ============================================================================
// Module : rf_pkg
// Brief  : Shared widths and write-port arbitration helper for the register file
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int DEF_RF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH       = 16;
  localparam int DEF_NUM_RD_PORTS     = 2;
  localparam int DEF_NUM_WR_PORTS     = 2;
  localparam int MAX_PORTS            = 8;

  typedef logic [MAX_PORTS-1:0] port_mask_t;

  // One-hot of the highest-index set bit; higher write ports take priority.
  function automatic port_mask_t wr_winner(input port_mask_t hit);
    port_mask_t sel;
    sel = '0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (hit[p]) begin
        sel    = '0;
        sel[p] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module : rf_scoreboard
// Brief  : Per-register busy bits for RAW hazard detection at issue
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int RF_ADDRESS_WIDTH = DEF_RF_ADDRESS_WIDTH,
  parameter int NUM_RD_PORTS     = DEF_NUM_RD_PORTS,
  parameter int NUM_WR_PORTS     = DEF_NUM_WR_PORTS,
  parameter int ZERO_REG         = 1,
  parameter int BYPASS           = 1
) (
  input  logic                                           clk,
  input  logic                                           asyn_n_rst,
  input  logic [NUM_WR_PORTS-1:0]                        we,
  input  logic [NUM_WR_PORTS-1:0][RF_ADDRESS_WIDTH-1:0]  rd,
  input  logic                                           issue_valid,
  input  logic [RF_ADDRESS_WIDTH-1:0]                    issue_rd,
  input  logic [NUM_RD_PORTS-1:0][RF_ADDRESS_WIDTH-1:0]  rs,
  output logic [NUM_RD_PORTS-1:0]                        rs_busy
);

  localparam int DEPTH = 2**RF_ADDRESS_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clears are applied before the set so a same-cycle issue keeps the bit high.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (we[p]) w_busy_nxt[rd[p]] = 1'b0;
    end
    if (issue_valid && !((ZERO_REG != 0) && (issue_rd == '0))) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) r_busy <= '0;
    else             r_busy <= w_busy_nxt;
  end

  generate
    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rs_busy
      logic w_wr_hit;
      always_comb begin
        w_wr_hit = 1'b0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (we[p] && (rd[p] == rs[i])) w_wr_hit = 1'b1;
        end
        rs_busy[i] = asyn_n_rst && r_busy[rs[i]] && !((BYPASS != 0) && w_wr_hit);
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rf_mp_scoreboard.sv
// ============================================================================
// Module : rf_mp_scoreboard
// Brief  : Multi-port register file with write bypass and busy scoreboard
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_mp_scoreboard
  import rf_pkg::*;
#(
  parameter int RF_ADDRESS_WIDTH = DEF_RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int NUM_RD_PORTS     = DEF_NUM_RD_PORTS,
  parameter int NUM_WR_PORTS     = DEF_NUM_WR_PORTS,
  parameter int ZERO_REG         = 1,
  parameter int BYPASS           = 1
) (
  input  logic                                           clk,
  input  logic                                           asyn_n_rst,
  input  logic [NUM_WR_PORTS-1:0]                        we,
  input  logic [NUM_WR_PORTS-1:0][RF_ADDRESS_WIDTH-1:0]  rd,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]        data_in,
  input  logic [NUM_RD_PORTS-1:0][RF_ADDRESS_WIDTH-1:0]  rs,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]        Qs,
  output logic [NUM_RD_PORTS-1:0]                        rs_busy,
  input  logic                                           issue_valid,
  input  logic [RF_ADDRESS_WIDTH-1:0]                    issue_rd
);

  localparam int DEPTH = 2**RF_ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Ports are visited in ascending order, so the last NBA (highest index) wins.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (we[p] && !((ZERO_REG != 0) && (rd[p] == '0))) begin
          r_mem[rd[p]] <= data_in[p];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd_port
      port_mask_t            w_hit;
      port_mask_t            w_sel;
      logic [DATA_WIDTH-1:0] w_byp;

      always_comb begin
        w_hit = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          w_hit[p] = we[p] && (rd[p] == rs[i]);
        end
        w_sel = wr_winner(w_hit);
        w_byp = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (w_sel[p]) w_byp = data_in[p];
        end

        Qs[i] = r_mem[rs[i]];
        if ((BYPASS != 0) && (w_hit != '0)) Qs[i] = w_byp;
        if ((ZERO_REG != 0) && (rs[i] == '0)) Qs[i] = '0;
        if (!asyn_n_rst) Qs[i] = '0;
      end
    end
  endgenerate

  rf_scoreboard #(
    .RF_ADDRESS_WIDTH (RF_ADDRESS_WIDTH),
    .NUM_RD_PORTS     (NUM_RD_PORTS),
    .NUM_WR_PORTS     (NUM_WR_PORTS),
    .ZERO_REG         (ZERO_REG),
    .BYPASS           (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .asyn_n_rst  (asyn_n_rst),
    .we          (we),
    .rd          (rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs          (rs),
    .rs_busy     (rs_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_mp_scoreboard.sv
// ============================================================================
// Module : tb_rf_mp_scoreboard
// Brief  : Self-checking bench for rf_mp_scoreboard (default parameters)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_mp_scoreboard;

  logic             clk;
  logic             rst_n;
  logic [1:0]       we;
  logic [1:0][4:0]  rd;
  logic [1:0][15:0] data_in;
  logic [1:0][4:0]  rs;
  logic [1:0][15:0] qs;
  logic [1:0]       rs_busy;
  logic             issue_valid;
  logic [4:0]       issue_rd;

  int checks = 0;
  int errors = 0;

  rf_mp_scoreboard dut (
    .clk         (clk),
    .asyn_n_rst  (rst_n),
    .we          (we),
    .rd          (rd),
    .data_in     (data_in),
    .rs          (rs),
    .Qs          (qs),
    .rs_busy     (rs_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state: register contents and outstanding producers.
  logic [15:0] m_mem  [32];
  logic        m_busy [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  <= 16'h0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (we[p] && rd[p] != 5'd0) m_mem[rd[p]] <= data_in[p];
        if (we[p]) m_busy[rd[p]] <= 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] <= 1'b1;
    end
  end

  function automatic logic [15:0] exp_q(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 16'h0;
    if (we[1] && rd[1] == a) return data_in[1];
    if (we[0] && rd[0] == a) return data_in[0];
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic written;
    written = (we[0] && rd[0] == a) || (we[1] && rd[1] == a);
    if (!rst_n) return 1'b0;
    return m_busy[a] && !written;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_q[%0d] rs=%0d", i, rs[i]), qs[i], exp_q(rs[i]));
      check($sformatf("model_busy[%0d] rs=%0d", i, rs[i]), {15'h0, rs_busy[i]}, {15'h0, exp_busy(rs[i])});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 2'b00;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 2'b00; rd = '0; data_in = '0; rs = '0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    repeat (2) step();
    #2;
    check("reset_q0", qs[0], 16'h0);
    check("reset_busy", {14'h0, rs_busy}, 16'h0);
    rst_n = 1'b1;

    // Test 1: every register reads zero, not busy
    for (int i = 0; i < 32; i++) begin
      step();
      rs[0] = 5'(i); rs[1] = 5'(31 - i);
    end

    // Test 2: fill regs 1..31 through port 0
    for (int i = 1; i < 32; i++) begin
      step();
      we = 2'b01; rd[0] = 5'(i); data_in[0] = 16'(i) + 16'h0100;
      rs[0] = 5'(i); rs[1] = 5'(i - 1);
    end
    step();
    idle();
    rs[0] = 5'd3; rs[1] = 5'd0;
    #2;
    check("readback_r3", qs[0], 16'h0103);
    check("readback_r0", qs[1], 16'h0000);
    for (int i = 0; i < 32; i++) begin
      step();
      rs[0] = 5'(i); rs[1] = 5'(31 - i);
    end

    // Test 3: two ports write r5 on one edge; port 1 wins
    step();
    we = 2'b11; rd[0] = 5'd5; rd[1] = 5'd5;
    data_in[0] = 16'h1111; data_in[1] = 16'h2222;
    rs[0] = 5'd5; rs[1] = 5'd31;
    #2;
    check("bypass_prio", qs[0], 16'h2222);
    step();
    idle();
    #2;
    check("mem_prio", qs[0], 16'h2222);

    // Test 4: issue r7, then its writeback clears busy
    step();
    issue_valid = 1'b1; issue_rd = 5'd7; rs[0] = 5'd7; rs[1] = 5'd7;
    #2;
    check("busy_before_edge", {15'h0, rs_busy[0]}, 16'h0);
    step();
    idle();
    #2;
    check("busy_after_issue", {15'h0, rs_busy[0]}, 16'h1);
    step();
    we = 2'b01; rd[0] = 5'd7; data_in[0] = 16'h0777;
    #2;
    check("busy_bypassed", {15'h0, rs_busy[0]}, 16'h0);
    check("q_bypassed_r7", qs[0], 16'h0777);
    step();
    idle();
    #2;
    check("busy_cleared", {15'h0, rs_busy[1]}, 16'h0);

    // Test 5: set beats clear on r9; writes to r0 ignored
    step();
    issue_valid = 1'b1; issue_rd = 5'd9;
    we = 2'b11; rd[1] = 5'd9; data_in[1] = 16'h0999;
    rd[0] = 5'd0; data_in[0] = 16'hFFFF;
    rs[0] = 5'd9; rs[1] = 5'd0;
    #2;
    check("r0_write_bypass", qs[1], 16'h0000);
    step();
    idle();
    #2;
    check("set_wins", {15'h0, rs_busy[0]}, 16'h1);
    check("r9_data", qs[0], 16'h0999);
    check("r0_after_write", qs[1], 16'h0000);
    step();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    idle();
    #2;
    check("r0_never_busy", {15'h0, rs_busy[1]}, 16'h0);

    // Test 6: asynchronous reset with a write in flight
    step();
    we = 2'b01; rd[0] = 5'd12; data_in[0] = 16'hABCD;
    issue_valid = 1'b1; issue_rd = 5'd13;
    step();
    idle();
    rs[0] = 5'd12; rs[1] = 5'd13;
    #2;
    check("pre_rst_r12", qs[0], 16'hABCD);
    check("pre_rst_busy13", {15'h0, rs_busy[1]}, 16'h1);
    step();
    we = 2'b01; rd[0] = 5'd12; data_in[0] = 16'h5555; rs[1] = 5'd12;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_q0", qs[0], 16'h0);
    check("rst_async_q1_byp", qs[1], 16'h0);
    check("rst_async_busy", {14'h0, rs_busy}, 16'h0);
    step();
    #2;
    rst_n = 1'b1;
    idle();
    rs[0] = 5'd12; rs[1] = 5'd13;
    #1;
    check("post_rst_r12", qs[0], 16'h0);
    check("post_rst_busy13", {15'h0, rs_busy[1]}, 16'h0);
    for (int i = 0; i < 32; i++) begin
      step();
      rs[0] = 5'(i); rs[1] = 5'(31 - i);
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
